// File: rtl/bp_stream_to_lite.sv
// bp_stream_to_lite: gathers a header + narrow-beat BedRock stream into one wide lite message.
// Header layout, MSB first: {payload, size, addr, msg_type}; a message is 2**size bytes.
module bp_stream_to_lite #(
  parameter int paddr_width_p = 40,
  parameter int in_data_width_p = 64,
  parameter int out_data_width_p = 512,
  parameter int payload_width_p = 8,
  parameter logic [15:0] payload_mask_p = '0,
  localparam int in_msg_header_width_lp = payload_width_p + 3 + paddr_width_p + 4,
  localparam int out_msg_width_lp = in_msg_header_width_lp + out_data_width_p
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [in_msg_header_width_lp-1:0] in_msg_header_i,
  input  logic [in_data_width_p-1:0]        in_msg_data_i,
  input  logic                              in_msg_v_i,
  output logic                              in_msg_ready_and_o,
  input  logic                              in_msg_last_i,
  output logic [out_msg_width_lp-1:0]       out_msg_o,
  output logic                              out_msg_v_o,
  input  logic                              out_msg_ready_and_i
);
  localparam int n_lp = out_data_width_p / in_data_width_p;
  localparam int cnt_w_lp = n_lp > 1 ? $clog2(n_lp) : 1;
  localparam logic [cnt_w_lp-1:0] top_lp = cnt_w_lp'(n_lp - 1);
  typedef struct packed {
    logic [payload_width_p-1:0] payload;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [3:0]                 msg_type;
  } hdr_s;
  typedef enum logic {e_ready, e_full} state_e;
  state_e state, state_n;
  logic [cnt_w_lp-1:0] cnt, cnt_n;
  logic [cnt_w_lp:0] beats;
  logic [in_data_width_p-1:0] slot [n_lp];
  logic [out_data_width_p-1:0] data;
  hdr_s hdr_in, hdr_r;
  logic in_fire;
  assign hdr_in = in_msg_header_i;
  assign in_msg_ready_and_o = state == e_ready && !reset_i;
  assign out_msg_v_o = state == e_full;
  assign in_fire = in_msg_v_i && in_msg_ready_and_o;
  assign out_msg_o = {hdr_r, data};
  always_comb begin
    state_n = (in_fire && in_msg_last_i) ? e_full
            : (state == e_full && out_msg_ready_and_i) ? e_ready : state;
    cnt_n = !in_fire ? cnt : in_msg_last_i ? '0 : (cnt == top_lp) ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= e_ready;
      cnt <= '0;
      beats <= (cnt_w_lp+1)'(1);
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (in_fire && in_msg_last_i) beats <= {1'b0, cnt} + 1'b1;
    end
  always_ff @(posedge clk_i) begin
    if (in_fire) slot[cnt] <= in_msg_data_i;
    if (in_fire && cnt == '0) hdr_r <= hdr_in;
  end
  // Short messages are tiled across the full width by repeating the received beats.
  always_comb begin
    data = '0;
    for (int j = 0; j < n_lp; j++)
      data[j*in_data_width_p +: in_data_width_p] = slot[cnt_w_lp'(j % beats)];
  end
  if (out_data_width_p % in_data_width_p != 0) begin : g_bad_ratio
    $error("out_data_width_p must be a multiple of in_data_width_p");
  end
  int exp_beats;
  assign exp_beats = !payload_mask_p[hdr_in.msg_type] ? 1
                   : ((1 << hdr_in.size) / (in_data_width_p/8)) > 0 ? (1 << hdr_in.size) / (in_data_width_p/8) : 1;
  a_last_count: assert property (@(posedge clk_i) disable iff (reset_i)
    in_fire && in_msg_last_i |-> int'(cnt) + 1 == exp_beats);
  a_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    in_fire && cnt == top_lp |-> in_msg_last_i);
  a_hdr_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    in_fire && cnt != '0 |-> hdr_in.msg_type == hdr_r.msg_type && hdr_in.size == hdr_r.size);
endmodule

// File: tb/tb_bp_stream_to_lite.sv
// tb_bp_stream_to_lite: random and directed streams checked against a message-level model.
module tb_bp_stream_to_lite;
  localparam int HW = 55;
  localparam int MW = HW + 512;
  logic clk, rst;
  logic [HW-1:0] in_hdr;
  logic [63:0] in_data;
  logic in_v, in_ready, in_last;
  logic [MW-1:0] out_msg;
  logic out_v, out_ready;
  int checks = 0, errors = 0;
  bit rnd_ready = 0;

  bp_stream_to_lite #(.paddr_width_p(40), .in_data_width_p(64), .out_data_width_p(512),
    .payload_width_p(8), .payload_mask_p(16'h0002)) dut (
    .clk_i(clk), .reset_i(rst), .in_msg_header_i(in_hdr), .in_msg_data_i(in_data),
    .in_msg_v_i(in_v), .in_msg_ready_and_o(in_ready), .in_msg_last_i(in_last),
    .out_msg_o(out_msg), .out_msg_v_o(out_v), .out_msg_ready_and_i(out_ready));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] s,
                                           input logic [39:0] a, input logic [7:0] p);
    return {p, s, a, t};
  endfunction

  function automatic int nbeats(input logic [3:0] t, input logic [2:0] s);
    int b;
    b = (1 << s) / 8;
    return (t == 4'd1 && b > 1) ? b : 1;
  endfunction

  task automatic chk(input string nm, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Model: a message is complete when its last beat is accepted, and is held until consumed.
  logic [HW-1:0] m_hdr;
  logic [63:0] m_beats[$];
  logic [MW-1:0] m_exp;
  bit m_full = 0;
  always @(posedge clk or posedge rst) begin
    int k, w, p;
    bit acc;
    logic [63:0] b;
    if (rst) begin
      m_full = 0;
      m_beats.delete();
    end else begin
      acc = in_v && !m_full;
      if (m_full && out_ready) m_full = 0;
      if (acc) begin
        if (m_beats.size() == 0) m_hdr = in_hdr;
        m_beats.push_back(in_data);
        if (in_last) begin
          k = m_beats.size();
          w = k * 64;
          for (int i = 0; i < 512; i++) begin
            p = i % w;
            b = m_beats[p/64];
            m_exp[i] = b[p%64];
          end
          m_exp[MW-1:512] = m_hdr;
          m_beats.delete();
          m_full = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_out_v", MW'(out_v), MW'(0));
      chk("rst_in_ready", MW'(in_ready), MW'(0));
    end else begin
      chk("out_v", MW'(out_v), MW'(m_full));
      chk("in_ready", MW'(in_ready), MW'(!m_full));
      if (m_full) chk("out_msg", out_msg, m_exp);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom % 2);
  end

  task automatic send_beat(input logic [HW-1:0] h, input logic [63:0] d, input logic l, input int gap);
    bit acc;
    repeat (gap) begin @(posedge clk); #1; end
    in_hdr = h; in_data = d; in_last = l; in_v = 1;
    acc = 0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout got no accept exp accept within 200 cycles");
    end
    in_v = 0;
  endtask

  task automatic send_msg(input logic [3:0] t, input logic [2:0] s, input logic [39:0] a, input int maxgap);
    int n;
    n = nbeats(t, s);
    for (int i = 0; i < n; i++)
      send_beat(mk_hdr(t, s, a + 40'(i*8), 8'($urandom)), {$urandom, $urandom}, i == n-1,
                int'($urandom_range(0, maxgap)));
  endtask

  initial begin
    logic [63:0] da, db;
    rst = 1; in_v = 0; in_last = 0; in_hdr = '0; in_data = '0; out_ready = 0;
    #1;
    chk("init_out_v", MW'(out_v), MW'(0));
    chk("init_in_ready", MW'(in_ready), MW'(0));
    #13 rst = 0;
    @(posedge clk); #1;
    // 8-beat 64B write, then held output while a read beat waits.
    for (int i = 1; i <= 8; i++)
      send_beat(mk_hdr(4'd1, 3'd6, 40'h80000040 + 40'((i-1)*8), 8'h5A), {16{4'(i)}}, i == 8, 0);
    chk("t1_v", MW'(out_v), MW'(1));
    chk("t1_addr", MW'(out_msg[555:516]), MW'(40'h80000040));
    chk("t1_data", MW'(out_msg[511:0]), MW'({64'h8888888888888888, 64'h7777777777777777,
      64'h6666666666666666, 64'h5555555555555555, 64'h4444444444444444,
      64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111}));
    chk("t1_model", m_exp, {mk_hdr(4'd1, 3'd6, 40'h80000040, 8'h5A),
      64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555,
      64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111});
    fork
      begin repeat (5) @(posedge clk); #1 out_ready = 1; end
      send_beat(mk_hdr(4'd0, 3'd3, 40'h1000, 8'h01), 64'hDEADBEEF01234567, 1, 0);
    join
    chk("rd_data", MW'(out_msg[511:0]), MW'({8{64'hDEADBEEF01234567}}));
    chk("rd_model", MW'(m_exp[511:0]), MW'({8{64'hDEADBEEF01234567}}));
    // 2-beat 16B write.
    da = 64'h0123456789ABCDEF; db = 64'hFEDCBA9876543210;
    send_beat(mk_hdr(4'd1, 3'd4, 40'h2000, 8'h02), da, 0, 0);
    send_beat(mk_hdr(4'd1, 3'd4, 40'h2008, 8'h02), db, 1, 0);
    chk("w2_data", MW'(out_msg[511:0]), MW'({4{db, da}}));
    repeat (2) @(posedge clk); #1;
    // Reset in the middle of an 8-beat message.
    for (int i = 0; i < 3; i++)
      send_beat(mk_hdr(4'd1, 3'd6, 40'h3000 + 40'(i*8), 8'h03), 64'hBAD0BAD0BAD0BAD0, 0, 0);
    #2 rst = 1;
    #1 chk("mid_rst_ready", MW'(in_ready), MW'(0));
    chk("mid_rst_v", MW'(out_v), MW'(0));
    repeat (2) @(posedge clk);
    #3 rst = 0;
    @(posedge clk); #1;
    send_beat(mk_hdr(4'd0, 3'd3, 40'h4000, 8'h04), 64'hCAFEF00D55AA33CC, 1, 0);
    chk("post_rst_data", MW'(out_msg[511:0]), MW'({8{64'hCAFEF00D55AA33CC}}));
    chk("post_rst_addr", MW'(out_msg[555:516]), MW'(40'h4000));
    repeat (2) @(posedge clk); #1;
    // Reset while a message is held at the output.
    out_ready = 0;
    send_beat(mk_hdr(4'd0, 3'd3, 40'h5000, 8'h05), 64'h1234, 1, 0);
    #2 rst = 1;
    #1 chk("full_rst_v", MW'(out_v), MW'(0));
    repeat (2) @(posedge clk);
    #3 rst = 0;
    @(posedge clk); #1;
    out_ready = 1;
    // Back-to-back 8-beat writes with the consumer always ready.
    send_msg(4'd1, 3'd6, 40'h6000, 0);
    send_msg(4'd1, 3'd6, 40'h6040, 0);
    // Random traffic with random consumer back-pressure.
    rnd_ready = 1;
    for (int m = 0; m < 40; m++) begin
      int t;
      t = int'($urandom_range(0, 2));
      send_msg(t == 0 ? 4'd0 : t == 1 ? 4'd1 : 4'd3, 3'($urandom_range(0, 6)),
               {$urandom, 8'h00} & 40'hFFFFFFFFC0, 2);
    end
    rnd_ready = 0;
    @(posedge clk); #1 out_ready = 1;
    for (int t = 0; t < 20 && out_v; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 chk("drain_v", MW'(out_v), MW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_stream_to_lite.md
Name: bp_stream_to_lite

Overview:
- Downstream-side converter: accepts a BedRock stream (header + narrow data beat per handshake, last-flagged) and reassembles one BedRock lite message with a full-width data field.
- Sits between a narrow stream producer (network/wormhole endpoint, CCE/memory stream) and a lite-only client (config bus, UCE-style consumer, lite memory model).
- Single-buffered: one message in assembly or held at the output at a time.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p.
- in_data_width_p, "inv", stream beat data width (narrow), bits.
- out_data_width_p, "inv", lite message data width (wide), bits; integer multiple of in_data_width_p.
- payload_width_p, "inv", BedRock header payload width.
- payload_mask_p, 0, bitmask over msg_type; a set bit means the type carries data and may span multiple beats.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- in_msg_header_i  in  in_msg_header_width_lp  stream header, valid with in_msg_v_i.
- in_msg_data_i  in  in_data_width_p  stream beat data.
- in_msg_v_i  in  1  beat valid.
- in_msg_ready_and_o  out  1  beat accepted when v & ready_and.
- in_msg_last_i  in  1  final beat of the message.
- out_msg_o  out  out_msg_width_lp  lite message: {header, data}.
- out_msg_v_o  out  1  lite message valid.
- out_msg_ready_and_i  in  1  consumer ready; ready-valid-and.

Behaviour:
- N = out_data_width_p/in_data_width_p; beat counter width = SAFE_CLOG2(N).
- States: e_ready (accepting beats, counter = number accepted), e_full (message held at output).
- Reset (async assert, any state): state=e_ready, counter=0, out_msg_v_o=0, in_msg_ready_and_o=0 while reset_i high; data and header registers are not reset. Reset mid-message discards partial beats.
- e_ready: in_msg_ready_and_o=1, out_msg_v_o=0.
- First accepted beat (counter==0): capture the full header, including its addr, unmodified. Headers on later beats are ignored; their addr auto-increments upstream.
- Each accepted beat writes in_msg_data_i to slot[counter] (bits counter*in_data_width_p +: in_data_width_p); counter increments.
- Accepted beat with in_msg_last_i=1: next cycle state=e_full and counter=0. Latency is last-beat handshake at edge t, out_msg_v_o=1 after edge t.
- e_full: out_msg_v_o=1, in_msg_ready_and_o=0. Header and data are stable until out_msg_ready_and_i=1, then state=e_ready on the next edge.
- No same-cycle bypass; max throughput is one lite message per (beats+1) cycles.
- Output data replication: let k = beats received (1..N) and W = k*in_data_width_p. Output data = the low W bits of the assembly buffer repeated to fill out_data_width_p. This also covers single-beat sub-width messages.
- Messages with payload_mask_p[msg_type]==0 are single-beat: last must be set on beat 1. Data is passed through with the same replication rule.
- Expected beats = max((1<<size)/(in_data_width_p/8),1) for data types, else 1.
- Protocol assertions (simulation only):
  - last on a beat ≠ expected count.
  - Beat accepted with counter==N.
  - N not an integer.
  - Upstream header msg_type/size changing within a message.
- Overflow behaviour, if assertions are off: completion is still driven only by last; the counter saturates at N-1 and overwrites the top slot.

Test Plan:
- Config in=64, out=512, mask includes e_bedrock_mem_wr. Send an 8-beat write, size=64B, addr=0x8000_0040, data 0x11..11 … 0x88..88, last on beat 8 → one lite message 1 cycle after beat 8. Header addr=0x8000_0040, data={0x88..88,…,0x11..11}, in_ready low until consumed.
- Read command (no payload), size=8B, one beat, last=1 → out_msg_v_o next cycle. Data = beat replicated 8×.
- 2-beat write, size=16B, data A,B → output data {B,A} repeated 4×.
- Hold out_msg_ready_and_i=0 for 5 cycles after completion → out_msg_o stable, in_msg_ready_and_o=0 throughout, no beat accepted. Release → v drops next edge and ready rises.
- Assert reset_i asynchronously after beat 3 of 8 → out_msg_v_o=0 immediately. Then a fresh 1-beat message completes correctly with no stale beats.
- Back-to-back 8-beat messages with the consumer always ready → each output follows its last beat by 1 cycle and the second message's first beat is accepted the cycle after the first is consumed. Randomised v/ready gaps give identical results.
